conv_channel_sched: RTL and testbench

Sequencer for one convolution layer's output-channel loop. For each output channel it:
- drives the bias ROM load (cout, c_load);
- waits for the registered bias to become valid;
- issues one MAC-engine job per output position with a start/done handshake;
- advances to the next channel.

It sits between the layer-level controller (start/done) and the bias ROM plus MAC datapath.

---
 rtl/conv_channel_sched.sv | 111 +++++++++++
 tb/tb_conv_channel_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_sched.sv
// Output-channel loop sequencer for one convolution layer: loads the bias per channel,
// then issues one MAC job per output position through a start/done handshake.
module conv_channel_sched #(
  parameter int OC    = 7,
  parameter int NPOS  = 676,
  parameter int POS_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mac_done,
  output logic [3:0]       cout,
  output logic             c_load,
  output logic             bias_valid,
  output logic [POS_W-1:0] pos,
  output logic             mac_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BWAIT, S_ISSUE, S_WAIT, S_NEXT, S_FIN
  } state_t;

  localparam logic [3:0]       OC_LAST  = 4'(OC);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cout, w_cout_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cout  <= '0;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cout  <= w_cout_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cout_nxt  = r_cout;
    w_pos_nxt   = r_pos;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_cout_nxt  = '0;
          w_pos_nxt   = '0;
        end
      end
      // ROM registers the bias at the end of LOAD; BWAIT covers its output latency
      S_LOAD:  w_state_nxt = S_BWAIT;
      S_BWAIT: w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mac_done) begin
          if (r_pos == POS_LAST) begin
            w_pos_nxt   = '0;
            w_state_nxt = S_NEXT;
          end else begin
            w_pos_nxt   = r_pos + POS_W'(1);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_NEXT: begin
        if (r_cout == OC_LAST) begin
          w_state_nxt = S_FIN;
        end else begin
          w_cout_nxt  = r_cout + 4'd1;
          w_state_nxt = S_LOAD;
        end
      end
      S_FIN: begin
        w_cout_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are pure state decodes, so no input reaches an output combinationally
  always_comb begin
    c_load     = 1'b0;
    bias_valid = 1'b0;
    mac_start  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE:  busy       = 1'b0;
      S_LOAD:  c_load     = 1'b1;
      S_ISSUE: begin
        mac_start  = 1'b1;
        bias_valid = 1'b1;
      end
      S_WAIT:  bias_valid = 1'b1;
      S_NEXT:  bias_valid = 1'b1;
      S_FIN:   done       = 1'b1;
      default: busy       = 1'b1;
    endcase
  end

  assign cout = r_cout;
  assign pos  = r_pos;

endmodule

// File: tb/tb_conv_channel_sched.sv
// Bench for conv_channel_sched: three instances with different OC/NPOS, a scoreboard of
// c_load / mac_start / done events, and directed timing checks.
module tb_conv_channel_sched;

  logic       clk;
  logic       rst;
  logic [2:0] st, md_r, spur, mdw;
  logic [2:0] cl, bv, ms, bz, dn;
  logic [3:0] co [3];
  logic [9:0] ps [3];

  assign mdw = md_r | spur;

  conv_channel_sched #(.OC(1), .NPOS(2), .POS_W(10)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .mac_done(mdw[0]), .cout(co[0]), .c_load(cl[0]),
    .bias_valid(bv[0]), .pos(ps[0]), .mac_start(ms[0]), .busy(bz[0]), .done(dn[0]));
  conv_channel_sched #(.OC(0), .NPOS(3), .POS_W(10)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .mac_done(mdw[1]), .cout(co[1]), .c_load(cl[1]),
    .bias_valid(bv[1]), .pos(ps[1]), .mac_start(ms[1]), .busy(bz[1]), .done(dn[1]));
  conv_channel_sched #(.OC(15), .NPOS(1), .POS_W(10)) u_dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .mac_done(mdw[2]), .cout(co[2]), .c_load(cl[2]),
    .bias_valid(bv[2]), .pos(ps[2]), .mac_start(ms[2]), .busy(bz[2]), .done(dn[2]));

  typedef struct {
    int inst;
    int kind;   // 0 = c_load, 1 = mac_start, 2 = done
    int cout;
    int pos;
  } ev_t;

  ev_t q[$];
  int  nvec = 0;
  int  nerr = 0;
  int  n_cyc;

  int  stall_pos [3];
  int  stall_len [3];
  int  stall_left[3];
  logic [2:0] pend;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int k, input int kind, input int c, input int p);
    ev_t e;
    e.inst = k; e.kind = kind; e.cout = c; e.pos = p;
    q.push_back(e);
  endtask

  task automatic push_layer(input int k, input int oc, input int np);
    for (int c = 0; c <= oc; c++) begin
      push_ev(k, 0, c, 0);
      for (int p = 0; p < np; p++) push_ev(k, 1, c, p);
    end
    push_ev(k, 2, oc, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  // Raise start for one cycle; returns #1 after the sampling edge with n_cyc cleared
  task automatic pulse_start(input int k);
    @(posedge clk);
    #1 st[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
    n_cyc = 0;
  endtask

  task automatic wait_done(input int k, input int budget);
    while (!dn[k] && n_cyc < budget) tick();
  endtask

  // MAC engine model: answers mac_done in the cycle after mac_start, optionally stalled
  initial begin
    md_r = '0;
    pend = '0;
    for (int k = 0; k < 3; k++) begin
      stall_pos[k] = -1; stall_len[k] = 0; stall_left[k] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        md_r[k] = 1'b0;
        if (rst) begin
          pend[k] = 1'b0;
        end else begin
          if (pend[k]) begin
            if (stall_left[k] > 0) stall_left[k]--;
            else begin
              md_r[k] = 1'b1;
              pend[k] = 1'b0;
            end
          end
          if (ms[k]) begin
            pend[k] = 1'b1;
            if (int'(ps[k]) == stall_pos[k]) begin
              stall_left[k] = stall_len[k];
              stall_pos[k]  = -1;
            end
          end
        end
      end
    end
  end

  ev_t mon_e;
  int  mon_kind;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (cl[k] && ms[k]) chk($sformatf("excl_inst%0d", k), 1, 0);
        if (cl[k] || ms[k] || dn[k]) begin
          mon_kind = cl[k] ? 0 : (ms[k] ? 1 : 2);
          if (q.size() == 0 || q[0].inst != k) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_event inst=%0d: got kind=%0d cout=%0d pos=%0d, required no event",
                     k, mon_kind, co[k], ps[k]);
          end else begin
            mon_e = q.pop_front();
            chk($sformatf("ev_kind_inst%0d", k), mon_kind, mon_e.kind);
            chk($sformatf("ev_cout_inst%0d", k), int'(co[k]), mon_e.cout);
            chk($sformatf("ev_pos_inst%0d", k), int'(ps[k]), mon_e.pos);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    st   = '0;
    spur = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), int'(bz[k]), 0);
      chk($sformatf("rst_cout%0d", k), int'(co[k]), 0);
      chk($sformatf("rst_pos%0d", k), int'(ps[k]), 0);
      chk($sformatf("rst_strobes%0d", k), int'({cl[k], bv[k], ms[k], dn[k]}), 0);
    end
    rst = 1'b0;

    // Full layer OC=1 NPOS=2: 2*(3+2*2) = 14 cycles to done
    push_layer(0, 1, 2);
    pulse_start(0);
    chk("full_load_first", int'(cl[0]), 1);
    wait_done(0, 100);
    chk("full_done_lat", n_cyc, 14);
    tick();
    chk("full_busy_after", int'(bz[0]), 0);
    chk("full_cout_after", int'(co[0]), 0);

    // Reset in WAIT of channel 1
    push_layer(0, 1, 2);
    pulse_start(0);
    while (!(ms[0] && co[0] == 4'd1) && n_cyc < 100) tick();
    chk("rstmid_reach_issue_c1", int'(ms[0]), 1);
    tick();
    chk("rstmid_in_wait_bv", int'(bv[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    chk("rstmid_busy", int'(bz[0]), 0);
    chk("rstmid_cout", int'(co[0]), 0);
    chk("rstmid_pos", int'(ps[0]), 0);
    chk("rstmid_strobes", int'({cl[0], bv[0], ms[0], dn[0]}), 0);
    repeat (3) tick();
    chk("rstmid_still_idle", int'(bz[0]), 0);
    push_layer(0, 1, 2);
    pulse_start(0);
    wait_done(0, 100);
    chk("rstmid_rerun_lat", n_cyc, 14);

    // Spurious start while busy and mac_done in LOAD/BWAIT/ISSUE
    push_layer(0, 1, 2);
    tick();
    pulse_start(0);
    st[0]   = 1'b1;
    spur[0] = 1'b1;
    tick();
    chk("spur_bwait_bv", int'(bv[0]), 0);
    tick();
    chk("spur_issue_ms", int'(ms[0]), 1);
    tick();
    spur[0] = 1'b0;
    st[0]   = 1'b0;
    chk("spur_wait_pos", int'(ps[0]), 0);
    wait_done(0, 100);
    chk("spur_done_lat", n_cyc, 14);
    repeat (4) tick();
    chk("spur_no_rerun", int'(bz[0]), 0);

    // Stalled handshake OC=0 NPOS=3, 5 extra WAIT cycles on pos=1: 9+5 = 14
    stall_len[1] = 5;
    stall_pos[1] = 1;
    push_layer(1, 0, 3);
    pulse_start(1);
    while (!(ms[1] && ps[1] == 10'd1) && n_cyc < 100) tick();
    chk("stall_issue_pos1", int'(ms[1]), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pos_held", int'(ps[1]), 1);
      chk("stall_no_restart", int'(ms[1]), 0);
      chk("stall_bias_valid", int'(bv[1]), 1);
    end
    wait_done(1, 100);
    chk("stall_done_lat", n_cyc, 14);
    tick();
    chk("stall_busy_after", int'(bz[1]), 0);

    // Max channels OC=15 NPOS=1: 16*5 = 80 cycles
    push_layer(2, 15, 1);
    pulse_start(2);
    wait_done(2, 200);
    chk("max_done_lat", n_cyc, 80);
    chk("max_cout_at_fin", int'(co[2]), 15);
    tick();
    chk("max_cout_after", int'(co[2]), 0);
    chk("max_busy_after", int'(bz[2]), 0);

    // Back-to-back: start raised in FIN, taken in IDLE
    push_layer(0, 1, 2);
    push_layer(0, 1, 2);
    pulse_start(0);
    wait_done(0, 100);
    chk("b2b_first_lat", n_cyc, 14);
    st[0] = 1'b1;
    tick();
    chk("b2b_fin_not_taken", int'(bz[0]), 0);
    chk("b2b_idle_no_load", int'(cl[0]), 0);
    tick();
    st[0] = 1'b0;
    chk("b2b_load_2_after_fin", int'(cl[0]), 1);
    n_cyc = 0;
    wait_done(0, 100);
    chk("b2b_second_lat", n_cyc, 14);
    repeat (3) tick();
    chk("b2b_busy_after", int'(bz[0]), 0);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
